// File: rtl/inv_cipher_iter_ctrl.sv
// Iterative AES inverse cipher: one shared inverse-round datapath driven by a
// round-counter FSM, AES-128/192/256, valid/ready on both ciphertext and plaintext.
module inv_cipher_iter_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  input  logic [1:0]    size,
  input  logic [1919:0] key_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output logic [3:0]    key_idx,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_e;

  // Byte x of the inverse S-box lives at bits [8*(255-x) +: 8].
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  state_e      st_q, st_d;
  logic [127:0] blk_q, blk_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [3:0]   nr_q, nr_d;
  logic [3:0]   nr_sel;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic [127:0] mix_out;
  logic [127:0] round_out;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by one of the InvMixColumns constants 09/0b/0d/0e.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] a2, a4, a8;
    a2 = xt(a);
    a4 = xt(a2);
    a8 = xt(a4);
    return a8 ^ (c[2] ? a4 : 8'h00) ^ (c[1] ? a2 : 8'h00) ^ (c[0] ? a : 8'h00);
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9);
      r[119-32*c -: 8] = gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd);
      r[111-32*c -: 8] = gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb);
      r[103-32*c -: 8] = gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he);
    end
    return r;
  endfunction

  // Row r rotates right by r columns; bytes are column-major (index r + 4c).
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int row = 0; row < 4; row++) begin
      for (int c = 0; c < 4; c++) begin
        b = s[127-8*(row+4*((c-row+4)%4)) -: 8];
        r[127-8*(row+4*c) -: 8] = INV_SBOX[{~b, 3'b000} +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rk_sel(input logic [1919:0] ks, input logic [3:0] k);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 15; i++) begin
      if (k == 4'(i)) r = ks[128*i +: 128];
    end
    return r;
  endfunction

  always_comb begin
    case (size)
      2'b00:   nr_sel = 4'd10;
      2'b01:   nr_sel = 4'd12;
      default: nr_sel = 4'd14;
    endcase
  end

  // One key mux serves both the whitening XOR at accept and every round.
  assign rk_idx    = (st_q == S_IDLE) ? nr_sel : (nr_q - rnd_q);
  assign rk        = rk_sel(key_out, rk_idx);
  assign mix_out   = (rnd_q == 4'd1) ? blk_q : inv_mix(blk_q);
  assign round_out = inv_shift_sub(mix_out) ^ rk;

  always_comb begin
    st_d  = st_q;
    blk_d = blk_q;
    rnd_d = rnd_q;
    nr_d  = nr_q;
    case (st_q)
      S_IDLE: begin
        if (in_valid) begin
          blk_d = in_data ^ rk;
          nr_d  = nr_sel;
          rnd_d = 4'd1;
          st_d  = S_ROUND;
        end
      end
      S_ROUND: begin
        blk_d = round_out;
        if (rnd_q == nr_q) st_d = S_DONE;
        else               rnd_d = rnd_q + 4'd1;
      end
      S_DONE: begin
        if (out_ready) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= S_IDLE;
      blk_q <= '0;
      rnd_q <= 4'd0;
      nr_q  <= 4'd10;
    end else begin
      st_q  <= st_d;
      blk_q <= blk_d;
      rnd_q <= rnd_d;
      nr_q  <= nr_d;
    end
  end

  // Outputs decode registered state only.
  assign in_ready  = (st_q == S_IDLE);
  assign out_valid = (st_q == S_DONE);
  assign busy      = (st_q != S_IDLE);
  assign out_data  = blk_q;

  always_comb begin
    key_idx = nr_q;
    case (st_q)
      S_ROUND: key_idx = nr_q - rnd_q;
      S_DONE:  key_idx = 4'd0;
      default: ;
    endcase
  end

endmodule
